// File: rtl/tristate_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tristate_bus_pkg
// Description : Shared types and defaults for the tristate bus controller.
//               Holds the FSM state encoding, the default transfer width and
//               turnaround length, and the bit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tristate_bus_pkg;

    localparam int DATA_W_DEFAULT   = 8;
    localparam int TURN_CYC_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN   = 2'd2,
        SAMPLE = 2'd3
    } bus_state_t;

    // The counter only ever holds reload values of (length - 1), so it needs
    // enough bits for max(DATA_W, TURN_CYC) - 1.
    function automatic int cnt_width(input int data_w, input int turn_cyc);
        int m;
        m = (data_w > turn_cyc) ? data_w : turn_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : bus_shift_reg
// Description : Left-shifting register shared by the drive and sample phases.
//               Parallel load for writes (MSB leaves first), serial-in for
//               reads (bits enter at the LSB end, so the first bit ends up
//               as the MSB).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               load, load_data - parallel load (has priority over shift)
//               shift_en        - shift one position towards the MSB
//               serial_in       - bit entering at the LSB
//               par_out         - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module bus_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (load) begin
            r_shift <= load_data;
        end else if (shift_en) begin
            r_shift <= {r_shift[WIDTH-2:0], serial_in};
        end
    end

    assign par_out = r_shift;

endmodule
`default_nettype wire

// File: rtl/tristate_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tristate_bus_ctrl
// Description : Half-duplex serial controller for one shared tristate wire.
//               Writes drive DATA_W bits MSB first, then release the bus for
//               TURN_CYC cycles. Reads release the bus for TURN_CYC cycles,
//               then sample DATA_W bits MSB first and pulse rx_valid.
//               The tristate buffer itself lives outside this block.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               cmd_valid/cmd_ready      - command handshake (ready only in IDLE)
//               cmd_read, cmd_data       - direction and write payload
//               buf_data, buf_enable     - to external tristate buffer
//               bus_in                   - resolved shared wire
//               rx_valid, rx_data        - read result
// Revision    : 1.0 - initial release
// ============================================================================
module tristate_bus_ctrl
    import tristate_bus_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int TURN_CYC = TURN_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              buf_data,
    output logic              buf_enable,
    input  logic              bus_in,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = cnt_width(DATA_W, TURN_CYC);
    localparam logic [CNT_W-1:0] c_data_reload = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_turn_reload = CNT_W'(TURN_CYC - 1);

    bus_state_t        r_state;
    bus_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_is_read;
    logic              r_rx_valid;
    logic [DATA_W-1:0] r_rx_data;

    logic              w_accept;
    logic              w_cnt_zero;
    logic              w_last_sample;
    logic              w_shift_en;
    logic              w_serial_in;
    logic [DATA_W-1:0] w_par;

    // Gating with rst keeps a command from being taken while reset is held.
    assign cmd_ready     = (r_state == IDLE) && !rst;
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_last_sample = (r_state == SAMPLE) && w_cnt_zero;
    assign w_shift_en    = (r_state == DRIVE) || (r_state == SAMPLE);
    assign w_serial_in   = (r_state == SAMPLE) && bus_in;

    // ------------------------------------------------------------------
    // Next-state and counter reload
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = cmd_read ? TURN : DRIVE;
                    w_cnt_nxt   = cmd_read ? c_turn_reload : c_data_reload;
                end
            end
            DRIVE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = TURN;
                    w_cnt_nxt   = c_turn_reload;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            TURN: begin
                if (w_cnt_zero) begin
                    // The same turnaround state serves both directions: it
                    // precedes sampling on a read and follows driving on a write.
                    if (r_is_read) begin
                        w_state_nxt = SAMPLE;
                        w_cnt_nxt   = c_data_reload;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            SAMPLE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and read-result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_read  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rx_valid <= w_last_sample;
            if (w_accept) begin
                r_is_read <= cmd_read;
            end
            // rx_data is a separate holding register so that later writes,
            // which reuse the shift register, never disturb the last result.
            if (w_last_sample) begin
                r_rx_data <= {w_par[DATA_W-2:0], bus_in};
            end
        end
    end

    bus_shift_reg #(
        .WIDTH (DATA_W)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .load_data (cmd_data),
        .shift_en  (w_shift_en),
        .serial_in (w_serial_in),
        .par_out   (w_par)
    );

    assign buf_enable = (r_state == DRIVE);
    assign buf_data   = buf_enable && w_par[DATA_W-1];
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;

endmodule
`default_nettype wire

// File: doc/tristate_bus_ctrl.md
TRISTATE_BUS_CTRL -- requirements
Module: tristate_bus_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per transfer (legal range 2..32).
REQ-002 The block SHALL have parameter TURN_CYC, default 2, meaning bus-released turnaround cycles (legal range 1..15).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port cmd_valid  input  1  command request.
REQ-006 The block SHALL have port cmd_ready  output  1  command accept; high only in IDLE.
REQ-007 The block SHALL have port cmd_read  input  1  0 = write (drive), 1 = read (sample).
REQ-008 The block SHALL have port cmd_data  input  DATA_W  write payload.
REQ-009 The block SHALL have port buf_data  output  1  connects to tristate buffer data_in.
REQ-010 The block SHALL have port buf_enable  output  1  connects to tristate buffer enable.
REQ-011 The block SHALL have port bus_in  input  1  resolved shared wire, sampled during reads.
REQ-012 The block SHALL have port rx_valid  output  1  one-cycle pulse; read data available.
REQ-013 The block SHALL have port rx_data  output  DATA_W  read result; held until the next rx_valid.

Function
REQ-014 The block SHALL implement FSM states IDLE, DRIVE, TURN and SAMPLE.
REQ-015 A command SHALL be accepted on any cycle with cmd_valid && cmd_ready; cmd_read and cmd_data are captured on that edge.
REQ-016 A write accepted at cycle N SHALL cause DRIVE for cycles N+1..N+DATA_W, then TURN for TURN_CYC cycles, then IDLE.
REQ-017 In DRIVE, buf_enable SHALL be 1 and buf_data SHALL carry cmd_data MSB first, one bit per cycle.
REQ-018 A read accepted at cycle N SHALL cause TURN for cycles N+1..N+TURN_CYC, then SAMPLE for DATA_W cycles, then IDLE.
REQ-019 In SAMPLE, bus_in SHALL be shifted into rx_data MSB first on each edge.
REQ-020 rx_valid SHALL pulse for exactly one cycle, on the first IDLE cycle after the last sample.
REQ-021 cmd_ready SHALL be high in that same cycle, so back-to-back commands are allowed.
REQ-022 buf_enable SHALL be 0 in every state except DRIVE.
REQ-023 buf_data SHALL be 0 whenever buf_enable is 0.
REQ-024 A write SHALL be followed by at least TURN_CYC cycles with buf_enable=0 before any later drive or sample.
REQ-025 cmd_valid while cmd_ready=0 SHALL be ignored; it is neither queued nor able to corrupt the transfer in progress.
REQ-026 A single bit counter, width sufficient for max(DATA_W, TURN_CYC), SHALL count down to 0 and wrap to reload on every state change.
REQ-027 Neither rx_valid nor any rx_data update SHALL be produced by a write.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set state=IDLE, buf_enable=0, buf_data=0, rx_valid=0, rx_data=0 and counter=0.
REQ-029 cmd_ready SHALL read 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-030 rst asserted mid-DRIVE SHALL release the bus (buf_enable=0) on the following edge, and the partial transfer SHALL be abandoned.
REQ-031 rst asserted mid-SAMPLE SHALL suppress rx_valid and clear rx_data.

Structure
REQ-032 Package tristate_bus_pkg SHALL hold the FSM state enum, DATA_W and TURN_CYC defaults, and the counter-width function.
REQ-033 The block SHALL instantiate exactly one sub-module, bus_shift_reg: a parallel-load/serial-out and serial-in/parallel-out register shared by DRIVE and SAMPLE.
REQ-034 The tristate buffer itself SHALL NOT be instantiated inside this block; the integrator connects buf_data/buf_enable externally.

Verification
REQ-035 Write 8'hA5 accepted at cycle 10 -> buf_enable=1 for cycles 11..18, buf_data=1,0,1,0,0,1,0,1, buf_enable=0 for cycles 19..20, cmd_ready=1 at cycle 21.
REQ-036 Read accepted at cycle 10 with bus_in driven 8'h3C MSB first during cycles 13..20 -> buf_enable=0 throughout, rx_valid=1 only at cycle 21, rx_data=8'h3C.
REQ-037 Write 8'hFF, then a read issued on the first cycle cmd_ready=1 -> no cycle has buf_enable=1 adjacent to a sample cycle, and at least 2 released cycles separate drive and sample.
REQ-038 rst pulsed at the 4th DRIVE cycle of a write -> buf_enable=0 on the next cycle, cmd_ready=1 after rst drops, and no residual drive occurs.
REQ-039 cmd_valid held high with toggling cmd_data throughout a write -> only the originally captured byte appears on buf_data, and the next command is accepted only when cmd_ready=1.
REQ-040 With DATA_W=4 and TURN_CYC=1, a read of 4'h9 -> rx_valid at N+6 and rx_data=4'h9.
